// File: rtl/uart_rx_deser.sv
// UART receive deserializer: 2-flop line synchronizer, NCO-based 16x oversampling,
// start/data/parity/stop framing, valid/ready byte output, error and break flags.
module uart_rx_deser #(
  parameter int NcoWidth   = 16,
  parameter int BreakTicks = 320
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                rx_enable_i,
  input  logic [NcoWidth-1:0] nco_i,
  input  logic                parity_enable_i,
  input  logic                parity_odd_i,
  input  logic                rx_i,
  output logic [7:0]          rx_data_o,
  output logic                rx_valid_o,
  input  logic                rx_ready_i,
  output logic                frame_err_o,
  output logic                parity_err_o,
  output logic                overflow_o,
  output logic                break_o,
  output logic                idle_o
);

  localparam int BrkW = $clog2(BreakTicks + 1);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } state_e;

  function automatic logic parity_mismatch(input logic [7:0] data,
                                           input logic       par_bit,
                                           input logic       odd);
    return ((^data) ^ par_bit) != odd;
  endfunction

  logic                rx_meta_q, rx_s_q;
  logic [NcoWidth-1:0] acc_q, acc_d;
  logic [NcoWidth:0]   nco_sum_s;
  logic                tick_s;
  state_e              state_q, state_d;
  logic [3:0]          cnt_q, cnt_d;
  logic [2:0]          bit_idx_q, bit_idx_d;
  logic [7:0]          shift_q, shift_d;
  logic                par_err_q, par_err_d;
  logic [BrkW-1:0]     brk_cnt_q, brk_cnt_d;
  logic [7:0]          rx_data_q, rx_data_d;
  logic                rx_valid_q, rx_valid_d;
  logic                frame_err_q, frame_err_d;
  logic                parity_err_q, parity_err_d;
  logic                overflow_q, overflow_d;
  logic                break_q, break_d;
  logic                idle_q, idle_d;
  logic                mid_s, push_s, pop_s;

  // NCO: the carry out of the accumulator is the oversample tick.
  always_comb begin
    nco_sum_s = {1'b0, acc_q} + {1'b0, nco_i};
    if (rx_enable_i) begin
      acc_d  = nco_sum_s[NcoWidth-1:0];
      tick_s = nco_sum_s[NcoWidth];
    end else begin
      acc_d  = '0;
      tick_s = 1'b0;
    end
  end

  // Frame sequencing; every state change happens on a tick.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    bit_idx_d    = bit_idx_q;
    shift_d      = shift_q;
    par_err_d    = par_err_q;
    push_s       = 1'b0;
    frame_err_d  = 1'b0;
    parity_err_d = 1'b0;
    mid_s        = (cnt_q == 4'd7);
    if (!rx_enable_i) begin
      state_d   = ST_IDLE;
      cnt_d     = 4'd0;
      bit_idx_d = 3'd0;
      par_err_d = 1'b0;
    end else if (tick_s) begin
      cnt_d = cnt_q + 4'd1;
      case (state_q)
        ST_IDLE: begin
          cnt_d = 4'd0;
          if (!rx_s_q) begin
            state_d   = ST_START;
            bit_idx_d = 3'd0;
            par_err_d = 1'b0;
          end else begin
            state_d = ST_IDLE;
          end
        end
        ST_START: begin
          if (mid_s && rx_s_q) begin
            state_d = ST_IDLE;
            cnt_d   = 4'd0;
          end else if (cnt_q == 4'd15) begin
            state_d = ST_DATA;
          end else begin
            state_d = ST_START;
          end
        end
        ST_DATA: begin
          if (mid_s) begin
            shift_d = {rx_s_q, shift_q[7:1]};
          end else begin
            shift_d = shift_q;
          end
          if (cnt_q == 4'd15) begin
            if (bit_idx_q == 3'd7) begin
              state_d = parity_enable_i ? ST_PARITY : ST_STOP;
            end else begin
              bit_idx_d = bit_idx_q + 3'd1;
            end
          end else begin
            bit_idx_d = bit_idx_q;
          end
        end
        ST_PARITY: begin
          if (mid_s) begin
            par_err_d = parity_mismatch(shift_q, rx_s_q, parity_odd_i);
          end else begin
            par_err_d = par_err_q;
          end
          if (cnt_q == 4'd15) begin
            state_d = ST_STOP;
          end else begin
            state_d = ST_PARITY;
          end
        end
        ST_STOP: begin
          // Leave at mid-stop so the next start edge can be caught early.
          if (mid_s) begin
            state_d = ST_IDLE;
            cnt_d   = 4'd0;
            if (!rx_s_q) begin
              frame_err_d = 1'b1;
            end else begin
              push_s       = 1'b1;
              parity_err_d = par_err_q;
            end
          end else begin
            state_d = ST_STOP;
          end
        end
        default: begin
          state_d = ST_IDLE;
          cnt_d   = 4'd0;
        end
      endcase
    end else begin
      state_d = state_q;
    end
  end

  // Single-entry output buffer with overflow detection.
  always_comb begin
    pop_s      = rx_valid_q & rx_ready_i;
    rx_data_d  = rx_data_q;
    rx_valid_d = rx_valid_q;
    overflow_d = 1'b0;
    if (push_s && rx_valid_q && !pop_s) begin
      overflow_d = 1'b1;
    end else if (push_s) begin
      rx_data_d  = shift_q;
      rx_valid_d = 1'b1;
    end else if (pop_s) begin
      rx_valid_d = 1'b0;
    end else begin
      rx_valid_d = rx_valid_q;
    end
  end

  // Break detection; looks one sync stage ahead so break drops as rx_s rises.
  always_comb begin
    if (!rx_enable_i || rx_s_q) begin
      brk_cnt_d = '0;
    end else if (tick_s && (brk_cnt_q != BrkW'(BreakTicks))) begin
      brk_cnt_d = brk_cnt_q + BrkW'(1);
    end else begin
      brk_cnt_d = brk_cnt_q;
    end
    break_d = (brk_cnt_d >= BrkW'(BreakTicks)) && !rx_meta_q;
    idle_d  = (state_d == ST_IDLE) && rx_meta_q;
  end

  // State and registered outputs.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rx_meta_q    <= 1'b1;
      rx_s_q       <= 1'b1;
      acc_q        <= '0;
      state_q      <= ST_IDLE;
      cnt_q        <= 4'd0;
      bit_idx_q    <= 3'd0;
      shift_q      <= 8'd0;
      par_err_q    <= 1'b0;
      brk_cnt_q    <= '0;
      rx_data_q    <= 8'd0;
      rx_valid_q   <= 1'b0;
      frame_err_q  <= 1'b0;
      parity_err_q <= 1'b0;
      overflow_q   <= 1'b0;
      break_q      <= 1'b0;
      idle_q       <= 1'b1;
    end else begin
      rx_meta_q    <= rx_i;
      rx_s_q       <= rx_meta_q;
      acc_q        <= acc_d;
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      bit_idx_q    <= bit_idx_d;
      shift_q      <= shift_d;
      par_err_q    <= par_err_d;
      brk_cnt_q    <= brk_cnt_d;
      rx_data_q    <= rx_data_d;
      rx_valid_q   <= rx_valid_d;
      frame_err_q  <= frame_err_d;
      parity_err_q <= parity_err_d;
      overflow_q   <= overflow_d;
      break_q      <= break_d;
      idle_q       <= idle_d;
    end
  end

  assign rx_data_o    = rx_data_q;
  assign rx_valid_o   = rx_valid_q;
  assign frame_err_o  = frame_err_q;
  assign parity_err_o = parity_err_q;
  assign overflow_o   = overflow_q;
  assign break_o      = break_q;
  assign idle_o       = idle_q;

endmodule

// File: tb/tb_uart_rx_deser.sv
// Bench for uart_rx_deser: table of frames plus hand-written backpressure, glitch,
// break and disable sequences; delivered bytes are scored against an expected queue.
module tb_uart_rx_deser;

  localparam int Bit = 32;  // nco 0x8000 -> tick every 2 clk -> 32 clk per bit

  logic        clk = 1'b0;
  logic        rst_n, en, par_en, par_odd, rx, ready;
  logic [15:0] nco;
  logic [7:0]  rx_data;
  logic        rx_valid, frame_err, parity_err, overflow, brk, idle;

  int checks = 0, errors = 0;
  int cyc = 0, rise_cyc = 0;
  int ferr_cnt = 0, perr_cnt = 0, ovf_cnt = 0;
  logic prev_valid = 1'b0;
  logic [7:0] exp_q[$];
  logic [7:0] got_q[$];

  typedef struct packed {
    logic [7:0] data;
    logic       par_en;
    logic       par_odd;
    logic       par_bit;
    logic       stop;
    logic       exp_del;
    logic [1:0] exp_perr;
    logic [1:0] exp_ferr;
  } vec_t;
  vec_t vecs[0:7];

  uart_rx_deser dut (
    .clk_i          (clk),
    .rst_ni         (rst_n),
    .rx_enable_i    (en),
    .nco_i          (nco),
    .parity_enable_i(par_en),
    .parity_odd_i   (par_odd),
    .rx_i           (rx),
    .rx_data_o      (rx_data),
    .rx_valid_o     (rx_valid),
    .rx_ready_i     (ready),
    .frame_err_o    (frame_err),
    .parity_err_o   (parity_err),
    .overflow_o     (overflow),
    .break_o        (brk),
    .idle_o         (idle)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Observe on the falling edge, where inputs and outputs are stable.
  always @(negedge clk) begin
    if (rx_valid && ready) got_q.push_back(rx_data);
    ferr_cnt   <= ferr_cnt + (frame_err ? 1 : 0);
    perr_cnt   <= perr_cnt + (parity_err ? 1 : 0);
    ovf_cnt    <= ovf_cnt + (overflow ? 1 : 0);
    if (rx_valid && !prev_valid) rise_cyc <= cyc;
    prev_valid <= rx_valid;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  task automatic drain_check(input string name);
    logic [31:0] e;
    while (got_q.size() > 0) begin
      if (exp_q.size() > 0) e = {24'd0, exp_q.pop_front()};
      else e = 32'hDEAD;
      check({name, " byte"}, {24'd0, got_q.pop_front()}, e);
    end
    check({name, " missing"}, 32'(exp_q.size()), 32'd0);
    exp_q.delete();
  endtask

  task automatic drive_bit(input logic b);
    rx = b;
    repeat (Bit) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] d, input logic pe, input logic pb, input logic sb);
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(d[i]);
    if (pe) drive_bit(pb);
    drive_bit(sb);
    drive_bit(1'b1);
    drive_bit(1'b1);
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic align_even();
    while (cyc[0]) wait_clk(1);
  endtask

  initial begin
    int f0, p0, o0, s, lat;
    vecs[0] = '{8'hA5, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 2'd0, 2'd0};
    vecs[1] = '{8'h07, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 2'd0, 2'd0};
    vecs[2] = '{8'h07, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 2'd1, 2'd0};
    vecs[3] = '{8'h3C, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd1};
    vecs[4] = '{8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 2'd0, 2'd0};
    vecs[5] = '{8'hFF, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 2'd0, 2'd0};
    vecs[6] = '{8'h81, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 2'd1};
    vecs[7] = '{8'h5A, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 2'd1, 2'd0};

    rst_n = 1'b0; en = 1'b0; par_en = 1'b0; par_odd = 1'b0;
    rx = 1'b1; ready = 1'b0; nco = 16'h8000;
    repeat (3) @(negedge clk);
    check("reset data", {24'd0, rx_data}, 32'h00);
    check("reset valid", {31'd0, rx_valid}, 32'd0);
    check("reset errs", {29'd0, frame_err, parity_err, overflow}, 32'd0);
    check("reset break", {31'd0, brk}, 32'd0);
    check("reset idle", {31'd0, idle}, 32'd1);
    @(posedge clk); #1;
    rst_n = 1'b1; en = 1'b1; ready = 1'b1;
    wait_clk(8);

    // Table of single frames with ready held high.
    for (int i = 0; i < 8; i++) begin
      par_en = vecs[i].par_en; par_odd = vecs[i].par_odd;
      f0 = ferr_cnt; p0 = perr_cnt;
      if (vecs[i].exp_del) exp_q.push_back(vecs[i].data);
      send_frame(vecs[i].data, vecs[i].par_en, vecs[i].par_bit, vecs[i].stop);
      check($sformatf("vec%0d ferr", i), 32'(ferr_cnt - f0), {30'd0, vecs[i].exp_ferr});
      check($sformatf("vec%0d perr", i), 32'(perr_cnt - p0), {30'd0, vecs[i].exp_perr});
      drain_check($sformatf("vec%0d", i));
    end
    par_en = 1'b0; par_odd = 1'b0;

    // Short low glitch on an idle line.
    f0 = ferr_cnt; p0 = perr_cnt;
    rx = 1'b0; wait_clk(6); rx = 1'b1;
    wait_clk(3 * Bit);
    check("glitch flags", 32'((ferr_cnt - f0) + (perr_cnt - p0)), 32'd0);
    check("glitch idle", {31'd0, idle}, 32'd1);
    drain_check("glitch");

    // Backpressure: second byte overflows, first one is kept.
    ready = 1'b0; o0 = ovf_cnt;
    send_frame(8'h11, 1'b0, 1'b0, 1'b1);
    send_frame(8'h22, 1'b0, 1'b0, 1'b1);
    check("bp1 data", {24'd0, rx_data}, 32'h11);
    check("bp1 valid", {31'd0, rx_valid}, 32'd1);
    check("bp1 overflow", 32'(ovf_cnt - o0), 32'd1);
    exp_q.push_back(8'h11);
    ready = 1'b1; wait_clk(1); ready = 1'b0;
    wait_clk(2);
    drain_check("bp1");

    // Learn the start-to-valid latency, then pop exactly on the 0x44 push edge.
    o0 = ovf_cnt;
    align_even();
    s = cyc;
    send_frame(8'h33, 1'b0, 1'b0, 1'b1);
    lat = rise_cyc - s;
    check("bp2 latency", 32'((lat >= 306 && lat <= 309) ? 1 : 0), 32'd1);
    check("bp2 hold 0x33", {24'd0, rx_data}, 32'h33);
    exp_q.push_back(8'h33);
    exp_q.push_back(8'h44);
    align_even();
    fork
      send_frame(8'h44, 1'b0, 1'b0, 1'b1);
      begin
        repeat (lat - 1) @(posedge clk);
        #1 ready = 1'b1;
        @(posedge clk);
        #1 ready = 1'b0;
      end
    join
    check("bp2 data", {24'd0, rx_data}, 32'h44);
    check("bp2 valid", {31'd0, rx_valid}, 32'd1);
    check("bp2 overflow", 32'(ovf_cnt - o0), 32'd0);
    ready = 1'b1;
    wait_clk(2);
    drain_check("bp2");

    // Break: ~25 bit times low. Two full all-zero frames fail on their stop bit;
    // the third attempt sees the line rise after its data bit 4 and yields 0xE0.
    f0 = ferr_cnt; p0 = perr_cnt;
    rx = 1'b0;
    wait_clk(19 * Bit);
    check("break early", {31'd0, brk}, 32'd0);
    wait_clk(2 * Bit);
    check("break set", {31'd0, brk}, 32'd1);
    wait_clk(4 * Bit);
    exp_q.push_back(8'hE0);
    rx = 1'b1;
    wait_clk(1);
    check("break hold 1clk", {31'd0, brk}, 32'd1);
    wait_clk(1);
    check("break clear 2clk", {31'd0, brk}, 32'd0);
    wait_clk(5 * Bit);
    check("break ferr", 32'(ferr_cnt - f0), 32'd2);
    check("break perr", 32'(perr_cnt - p0), 32'd0);
    drain_check("break tail");
    exp_q.push_back(8'h5A);
    send_frame(8'h5A, 1'b0, 1'b0, 1'b1);
    drain_check("after break");

    // Disable during data bit 4; the partial frame must leave no trace.
    f0 = ferr_cnt; p0 = perr_cnt;
    fork
      send_frame(8'h96, 1'b0, 1'b0, 1'b1);
      begin
        wait_clk(5 * Bit + 16);
        en = 1'b0;
      end
    join
    en = 1'b1;
    wait_clk(Bit);
    check("disable flags", 32'((ferr_cnt - f0) + (perr_cnt - p0)), 32'd0);
    drain_check("disable");
    exp_q.push_back(8'hC3);
    send_frame(8'hC3, 1'b0, 1'b0, 1'b1);
    drain_check("after disable");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
